// File: rtl/key_debounce_pkg.sv
// Shared types and default timing constants for the key debounce block.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED       = 2'd0,
    SETTLE_PRESS   = 2'd1,
    PRESSED        = 2'd2,
    SETTLE_RELEASE = 2'd3
  } key_fsm_t;

  // 10 ms and 1 s at the 50 MHz board clock
  localparam int DEBOUNCE_CYCLES_50MHZ_10MS = 500000;
  localparam int LONG_PRESS_CYCLES_50MHZ_1S = 50000000;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, debounce FSM, qualification and hold counters.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_50MHZ_10MS,
  parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_50MHZ_1S
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  input  logic     i_key_n,
  output logic     o_state,
  output logic     o_press,
  output logic     o_release,
  output logic     o_long,
  output key_fsm_t o_fsm
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LONG = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);

  logic          r_sync1, r_sync2;
  logic          w_sync;
  key_fsm_t      r_fsm;
  logic [CW-1:0] r_cnt;
  logic [HW-1:0] r_hold;
  logic          r_state, r_press, r_release, r_long;

  assign w_sync = ~r_sync2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_fsm     <= RELEASED;
      r_cnt     <= '0;
      r_hold    <= '0;
      r_state   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
    end else begin
      r_sync1   <= i_key_n;
      r_sync2   <= r_sync1;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      case (r_fsm)
        RELEASED: begin
          if (w_sync) begin
            if (DEBOUNCE_CYCLES == 1) begin
              r_fsm   <= PRESSED;
              r_press <= 1'b1;
              r_state <= 1'b1;
              r_cnt   <= '0;
            end else begin
              r_fsm <= SETTLE_PRESS;
              r_cnt <= CW'(1);
            end
          end
        end
        SETTLE_PRESS: begin
          if (!w_sync) begin
            r_fsm <= RELEASED;
            r_cnt <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_fsm   <= PRESSED;
            r_press <= 1'b1;
            r_state <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        PRESSED: begin
          // Saturating at LONG_PRESS_CYCLES means HOLD_LONG is only ever seen once per press
          if (r_hold != HOLD_MAX) r_hold <= r_hold + HW'(1);
          if (r_hold == HOLD_LONG) r_long <= 1'b1;
          if (!w_sync) begin
            if (DEBOUNCE_CYCLES == 1) begin
              r_fsm     <= RELEASED;
              r_release <= 1'b1;
              r_state   <= 1'b0;
              r_hold    <= '0;
              r_cnt     <= '0;
            end else begin
              r_fsm <= SETTLE_RELEASE;
              r_cnt <= CW'(1);
            end
          end
        end
        SETTLE_RELEASE: begin
          if (w_sync) begin
            r_fsm <= PRESSED;
            r_cnt <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_fsm     <= RELEASED;
            r_release <= 1'b1;
            r_state   <= 1'b0;
            r_hold    <= '0;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_fsm <= RELEASED;
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign o_state   = r_state;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_long    = r_long;
  assign o_fsm     = r_fsm;

endmodule

// File: rtl/key_debounce.sv
// DE0-Nano KEY conditioning: one independent debounce channel per button.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int NUM_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_50MHZ_10MS,
  parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_50MHZ_1S
) (
  input  logic                  EXTCLK,
  input  logic                  RST_N,
  input  logic [NUM_KEYS-1:0]   KEY_N,
  output logic [NUM_KEYS-1:0]   key_state,
  output logic [NUM_KEYS-1:0]   key_press,
  output logic [NUM_KEYS-1:0]   key_release,
  output logic [NUM_KEYS-1:0]   key_long,
  output logic [2*NUM_KEYS-1:0] key_fsm_dbg
);

  key_fsm_t w_fsm [NUM_KEYS];

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
    ) u_ch (
      .i_clk    (EXTCLK),
      .i_rst_n  (RST_N),
      .i_key_n  (KEY_N[g]),
      .o_state  (key_state[g]),
      .o_press  (key_press[g]),
      .o_release(key_release[g]),
      .o_long   (key_long[g]),
      .o_fsm    (w_fsm[g])
    );
    assign key_fsm_dbg[2*g +: 2] = w_fsm[g];
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_CYCLES=8, LONG_PRESS_CYCLES=32.
module tb_key_debounce;

  localparam int NK = 2;
  localparam int DB = 8;
  localparam int LP = 32;

  logic          EXTCLK = 1'b0;
  logic          RST_N;
  logic [NK-1:0] KEY_N;
  logic [NK-1:0] key_state, key_press, key_release, key_long;
  logic [2*NK-1:0] key_fsm_dbg;

  int errors = 0;
  int checks = 0;

  key_debounce #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .LONG_PRESS_CYCLES(LP)
  ) dut (
    .EXTCLK(EXTCLK), .RST_N(RST_N), .KEY_N(KEY_N),
    .key_state(key_state), .key_press(key_press),
    .key_release(key_release), .key_long(key_long),
    .key_fsm_dbg(key_fsm_dbg)
  );

  always #5 EXTCLK = ~EXTCLK;

  // Advance one rising edge and settle 1 ns past it
  task automatic tick();
    @(posedge EXTCLK);
    #1;
  endtask

  task automatic test_reset();
    logic bad;
    RST_N = 1'b0;
    KEY_N = 2'b11;
    #23;
    checks++;
    if ({key_state, key_press, key_release, key_long} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000000",
               {key_state, key_press, key_release, key_long});
    end
    checks++;
    if (key_fsm_dbg !== 4'b0000) begin
      errors++;
      $display("FAIL reset_fsm: got %b expected 0000", key_fsm_dbg);
    end
    tick();
    RST_N = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if ({key_state, key_press, key_release, key_long} !== 8'h00) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_100: saw nonzero output, expected all 0 for 100 cycles");
    end
  endtask

  task automatic test_clean_press();
    logic [7:0] exp;
    KEY_N = 2'b10;
    for (int e = 1; e <= 12; e++) begin
      tick();
      exp = {1'b0, (e >= 10), 1'b0, (e == 10), 4'b0000};
      checks++;
      if ({key_state, key_press, key_release, key_long} !== exp) begin
        errors++;
        $display("FAIL clean_press edge %0d: got %b expected %b", e,
                 {key_state, key_press, key_release, key_long}, exp);
      end
    end
    KEY_N = 2'b11;
    for (int e = 1; e <= 12; e++) begin
      tick();
      exp = {1'b0, (e < 10), 2'b00, 1'b0, (e == 10), 2'b00};
      checks++;
      if ({key_state, key_press, key_release, key_long} !== exp) begin
        errors++;
        $display("FAIL clean_release edge %0d: got %b expected %b", e,
                 {key_state, key_press, key_release, key_long}, exp);
      end
    end
  endtask

  task automatic test_bounce();
    logic bad;
    logic [7:0] exp;
    bad = 1'b0;
    for (int r = 0; r < 4; r++) begin
      KEY_N = 2'b10;
      for (int i = 0; i < 5; i++) begin
        tick();
        if (key_press !== 2'b00 || key_state !== 2'b00) bad = 1'b1;
      end
      KEY_N = 2'b11;
      for (int i = 0; i < 2; i++) begin
        tick();
        if (key_press !== 2'b00 || key_state !== 2'b00) bad = 1'b1;
      end
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL bounce_reject: press/state rose during bounces, expected 0");
    end
    KEY_N = 2'b10;
    for (int e = 1; e <= 12; e++) begin
      tick();
      exp = {1'b0, (e >= 10), 1'b0, (e == 10), 4'b0000};
      checks++;
      if ({key_state, key_press, key_release, key_long} !== exp) begin
        errors++;
        $display("FAIL bounce_settle edge %0d: got %b expected %b", e,
                 {key_state, key_press, key_release, key_long}, exp);
      end
    end
    KEY_N = 2'b11;
    for (int e = 0; e < 12; e++) tick();
    checks++;
    if (key_state !== 2'b00) begin
      errors++;
      $display("FAIL bounce_cleanup: key_state=%b expected 00", key_state);
    end
  endtask

  task automatic test_long_press();
    logic [7:0] exp;
    KEY_N = 2'b10;
    for (int e = 1; e <= 60; e++) begin
      tick();
      exp = {1'b0, (e >= 10), 1'b0, (e == 10), 2'b00, 1'b0, (e == 10 + LP)};
      checks++;
      if ({key_state, key_press, key_release, key_long} !== exp) begin
        errors++;
        $display("FAIL long_hold edge %0d: got %b expected %b", e,
                 {key_state, key_press, key_release, key_long}, exp);
      end
    end
    KEY_N = 2'b11;
    for (int e = 1; e <= 12; e++) begin
      tick();
      exp = {1'b0, (e < 10), 2'b00, 1'b0, (e == 10), 2'b00};
      checks++;
      if ({key_state, key_press, key_release, key_long} !== exp) begin
        errors++;
        $display("FAIL long_release edge %0d: got %b expected %b", e,
                 {key_state, key_press, key_release, key_long}, exp);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [NK-1:0] ev;
    KEY_N = 2'b00;
    for (int e = 1; e <= 12; e++) begin
      tick();
      ev = (e == 10) ? 2'b11 : 2'b00;
      checks++;
      if (key_press !== ev || key_state !== ((e >= 10) ? 2'b11 : 2'b00)
          || key_release !== 2'b00) begin
        errors++;
        $display("FAIL simul_press edge %0d: state=%b press=%b release=%b expected press %b",
                 e, key_state, key_press, key_release, ev);
      end
    end
    KEY_N = 2'b11;
    for (int e = 1; e <= 12; e++) begin
      tick();
      ev = (e == 10) ? 2'b11 : 2'b00;
      checks++;
      if (key_release !== ev || key_state !== ((e < 10) ? 2'b11 : 2'b00)
          || key_press !== 2'b00) begin
        errors++;
        $display("FAIL simul_release edge %0d: state=%b press=%b release=%b expected release %b",
                 e, key_state, key_press, key_release, ev);
      end
    end
  endtask

  task automatic test_reset_mid_press();
    logic [7:0] exp;
    logic bad;
    KEY_N = 2'b10;
    for (int e = 0; e < 12; e++) tick();
    checks++;
    if (key_state !== 2'b01) begin
      errors++;
      $display("FAIL midrst_pre: key_state=%b expected 01", key_state);
    end
    RST_N = 1'b0;
    #1;
    checks++;
    if ({key_state, key_press, key_release, key_long} !== 8'h00) begin
      errors++;
      $display("FAIL midrst_async: got %b expected 00000000",
               {key_state, key_press, key_release, key_long});
    end
    tick();
    tick();
    RST_N = 1'b1;
    bad = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      tick();
      exp = {1'b0, (e >= 10), 1'b0, (e == 10), 4'b0000};
      if (key_release !== 2'b00) bad = 1'b1;
      checks++;
      if ({key_state, key_press, key_release, key_long} !== exp) begin
        errors++;
        $display("FAIL midrst_repress edge %0d: got %b expected %b", e,
                 {key_state, key_press, key_release, key_long}, exp);
      end
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_release: key_release pulsed, expected none");
    end
  endtask

  initial begin
    RST_N = 1'b0;
    KEY_N = 2'b11;
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_simultaneous();
    test_reset_mid_press();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
